fetch_sequencer: RTL and testbench

Controller that drives the 8-bit instruction memory and sequences the program counter for the fetch stage. It issues one read per cycle and resolves PC-relative jumps (opcode `2'b11`, 6-bit signed offset) with zero bubbles. Fetched instructions are buffered with their PC in a small queue and handed to decode over a valid/ready handshake. It sits between the instruction memory and the decode stage, and accepts an external redirect from later stages.

---
 rtl/fetch_sequencer_pkg.sv | 16 +
 rtl/fetch_sequencer_if.sv | 26 ++
 rtl/fetch_sequencer_queue.sv | 52 +++++
 rtl/fetch_sequencer.sv | 123 ++++++++++++
 tb/tb_fetch_sequencer.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared fetch-stage constants, FSM encoding and queue entry layout.
package fetch_pkg;

    localparam int         FETCH_ADDR_W  = 8;
    localparam int         FETCH_INSTR_W = 8;
    localparam logic [1:0] OPC_JUMP      = 2'b11;
    localparam logic [7:0] HALT_INSTR    = 8'hFF;

    typedef enum logic [1:0] {IDLE, PEND, HALT} fetch_state_e;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0]  pc;
        logic [FETCH_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Fetch-stage bus: instruction memory port, redirect input and decode handshake.
interface fetch_sequencer_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 8
);
    logic               imem_en;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;
    logic               halted;

    modport master (
        output imem_en, imem_addr, out_valid, out_instr, out_pc, halted,
        input  imem_rdata, redirect_valid, redirect_pc, out_ready
    );

    modport slave (
        input  imem_en, imem_addr, out_valid, out_instr, out_pc, halted,
        output imem_rdata, redirect_valid, redirect_pc, out_ready
    );
endinterface

// File: rtl/fetch_sequencer_queue.sv
// Small power-of-two FIFO of fetched {pc, instr}; head is read straight from storage.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter type entry_t = fetch_entry_t,
    parameter int  DEPTH   = 2,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  entry_t           i_data,
    output entry_t           o_head,
    output logic             o_valid,
    output logic [CNT_W-1:0] o_count
);

    entry_t           r_mem [DEPTH];
    logic [PTR_W-1:0] r_rd;
    logic [PTR_W-1:0] r_wr;
    logic [CNT_W-1:0] r_count;
    logic             w_pop;

    assign w_pop   = i_pop && (r_count != '0);
    assign o_head  = r_mem[r_rd];
    assign o_valid = (r_count != '0);
    assign o_count = r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= r_wr + PTR_W'(1);
            end
            if (w_pop) r_rd <= r_rd + PTR_W'(1);
            r_count <= r_count + CNT_W'(i_push) - CNT_W'(w_pop);
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: one imem read per cycle, zero-bubble PC-relative jumps,
// halt on jump-to-self, external redirect flush, buffered output to decode.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int ADDR_W      = FETCH_ADDR_W,
    parameter int INSTR_W     = FETCH_INSTR_W,
    parameter int QUEUE_DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    fetch_sequencer_if.master bus
);

    localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;
    localparam int OCC_W = CNT_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    fetch_state_e      r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_next_pc;
    logic              r_halted;

    logic              w_resp, w_push, w_pop, w_valid, w_room;
    logic              w_jump, w_halt, w_issue;
    logic [ADDR_W-1:0] w_off, w_tgt, w_issue_addr;
    logic [CNT_W-1:0]  w_count;
    logic [OCC_W-1:0]  w_occ;
    entry_t            w_head, w_in;

    // r_addr is the address of the read in flight while PEND, else the last one issued.
    assign w_resp = (r_state == PEND);
    assign w_jump = (bus.imem_rdata[INSTR_W-1 -: 2] == OPC_JUMP);
    assign w_halt = (bus.imem_rdata == INSTR_W'(HALT_INSTR));
    assign w_off  = ADDR_W'($signed(bus.imem_rdata[INSTR_W-3:0]));
    assign w_tgt  = r_addr + ADDR_W'(1) + (w_jump ? w_off : '0);

    assign w_push = w_resp && !bus.redirect_valid;
    assign w_pop  = w_valid && bus.out_ready;
    assign w_in   = '{pc: r_addr, instr: bus.imem_rdata};

    // One free slot after this cycle is kept for the data of the read issued now.
    assign w_occ  = OCC_W'(w_count) + OCC_W'(w_push) - OCC_W'(w_pop);
    assign w_room = (w_occ < OCC_W'(QUEUE_DEPTH));

    always_comb begin
        w_issue      = 1'b0;
        w_issue_addr = r_next_pc;
        if (reset) begin
            w_issue = 1'b0;
        end else if (bus.redirect_valid) begin
            w_issue      = 1'b1;
            w_issue_addr = bus.redirect_pc;
        end else begin
            case (r_state)
                IDLE: w_issue = w_room;
                PEND: begin
                    w_issue      = w_room && !w_halt;
                    w_issue_addr = w_tgt;
                end
                default: w_issue = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_next_pc <= '0;
            r_halted  <= 1'b0;
        end else if (bus.redirect_valid) begin
            r_state  <= PEND;
            r_addr   <= bus.redirect_pc;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_issue) begin
                    r_state <= PEND;
                    r_addr  <= w_issue_addr;
                end
                PEND: if (w_halt) begin
                    r_state  <= HALT;
                    r_halted <= 1'b1;
                end else if (w_issue) begin
                    r_addr <= w_tgt;
                end else begin
                    r_state   <= IDLE;
                    r_next_pc <= w_tgt;
                end
                HALT: r_state <= HALT;
                default: r_state <= IDLE;
            endcase
        end
    end

    fetch_queue #(
        .entry_t (entry_t),
        .DEPTH   (QUEUE_DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (bus.redirect_valid),
        .i_data  (w_in),
        .o_head  (w_head),
        .o_valid (w_valid),
        .o_count (w_count)
    );

    assign bus.imem_en   = w_issue;
    assign bus.imem_addr = w_issue ? w_issue_addr : r_addr;
    assign bus.out_valid = w_valid;
    assign bus.out_pc    = w_head.pc;
    assign bus.out_instr = w_head.instr;
    assign bus.halted    = r_halted;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: sequential, jumps, wrap, backpressure, redirect, halt.
module tb_fetch_sequencer;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    fetch_sequencer_if #(.ADDR_W(8), .INSTR_W(8)) bus ();

    fetch_sequencer #(.ADDR_W(8), .INSTR_W(8), .QUEUE_DEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [7:0] mem [256];

    // Synchronous instruction memory: data valid the cycle after the strobe.
    always @(posedge clk) if (bus.imem_en) bus.imem_rdata <= mem[bus.imem_addr];

    int n_vec = 0;
    int n_err = 0;
    int cyc;
    int iss_a[$], iss_c[$], out_p[$], out_i[$], out_c[$];

    // Transaction log indexed by cycle count since reset release.
    always @(negedge clk) begin
        if (reset) begin
            cyc = 0;
            iss_a.delete(); iss_c.delete();
            out_p.delete(); out_i.delete(); out_c.delete();
        end else begin
            if (bus.imem_en) begin
                iss_a.push_back(int'(bus.imem_addr));
                iss_c.push_back(cyc);
            end
            if (bus.out_valid && bus.out_ready) begin
                out_p.push_back(int'(bus.out_pc));
                out_i.push_back(int'(bus.out_instr));
                out_c.push_back(cyc);
            end
            cyc++;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int qv(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic fill_default();
        for (int a = 0; a < 256; a++) mem[a] = 8'((a + 1) & 63);
    endtask

    task automatic do_reset(input logic rdy);
        reset              = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 8'h00;
        bus.out_ready      = rdy;
        @(negedge clk);
        chk("rst_imem_en",   int'(bus.imem_en),   0);
        chk("rst_imem_addr", int'(bus.imem_addr), 0);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_pc",    int'(bus.out_pc),    0);
        chk("rst_out_instr", int'(bus.out_instr), 0);
        chk("rst_halted",    int'(bus.halted),    0);
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 8'h00;
        bus.out_ready      = 1'b0;

        // Sequential fetch 01,02,03
        fill_default();
        do_reset(1'b1);
        step(6);
        chk("seq_iss0", qv(iss_a, 0), 0);
        chk("seq_iss1", qv(iss_a, 1), 1);
        chk("seq_iss2", qv(iss_a, 2), 2);
        chk("seq_iss2_cyc", qv(iss_c, 2), 2);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("seq_out_pc%0d", i),    qv(out_p, i), i);
            chk($sformatf("seq_out_instr%0d", i), qv(out_i, i), i + 1);
        end
        chk("seq_first_valid_cyc", qv(out_c, 0), 2);

        // Forward jump 0xC3 at pc 2 -> 6, no bubble
        fill_default();
        mem[2] = 8'hC3;
        do_reset(1'b1);
        step(8);
        chk("jmp_iss_addr", qv(iss_a, 3), 6);
        chk("jmp_iss_cyc",  qv(iss_c, 3), 3);
        chk("jmp_out_instr2", qv(out_i, 2), 8'hC3);
        chk("jmp_out_pc3", qv(out_p, 3), 6);
        chk("jmp_out_pc4", qv(out_p, 4), 7);
        chk("jmp_out_cyc3", qv(out_c, 3), 5);
        chk("jmp_out_cyc4", qv(out_c, 4), 6);

        // Backward jump 0xE0 at 0x05 -> 0xE6, then wrap 0xFF -> 0x00
        fill_default();
        mem[5] = 8'hE0;
        do_reset(1'b1);
        step(36);
        chk("bwd_iss_addr", qv(iss_a, 6), 8'hE6);
        chk("bwd_iss_cyc",  qv(iss_c, 6), 6);
        chk("bwd_out_pc",   qv(out_p, 6), 8'hE6);
        chk("bwd_out_instr", qv(out_i, 6), 8'h27);
        chk("wrap_iss_ff",  qv(iss_a, 31), 8'hFF);
        chk("wrap_iss_00",  qv(iss_a, 32), 8'h00);
        chk("wrap_out_00",  qv(out_p, 32), 8'h00);

        // Backpressure: out_ready low for cycles 0..5
        fill_default();
        do_reset(1'b0);
        step(5);
        @(negedge clk);
        chk("bp_imem_en",   int'(bus.imem_en),   0);
        chk("bp_out_valid", int'(bus.out_valid), 1);
        chk("bp_out_pc",    int'(bus.out_pc),    0);
        chk("bp_iss_count", iss_a.size(), 2);
        step(1);
        bus.out_ready = 1'b1;
        step(10);
        chk("bp_resume_iss_cyc", qv(iss_c, 2), 6);
        chk("bp_out_cyc0", qv(out_c, 0), 6);
        chk("bp_out_cyc2", qv(out_c, 2), 8);
        for (int i = 0; i < 8; i++) chk($sformatf("bp_out_pc%0d", i), qv(out_p, i), i);
        chk("bp_out_count", out_p.size(), 10);

        // Redirect to 0x40 while a response is arriving and the queue holds pc 0
        fill_default();
        do_reset(1'b0);
        step(2);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 8'h40;
        @(negedge clk);
        chk("rd_imem_en",   int'(bus.imem_en),   1);
        chk("rd_imem_addr", int'(bus.imem_addr), 8'h40);
        step(1);
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        chk("rd_flushed_valid", int'(bus.out_valid), 0);
        step(1);
        @(negedge clk);
        chk("rd_out_valid", int'(bus.out_valid), 1);
        chk("rd_out_pc",    int'(bus.out_pc),    8'h40);
        chk("rd_out_instr", int'(bus.out_instr), 8'h01);
        step(1);
        bus.out_ready = 1'b1;
        step(4);
        chk("rd_seq_pc0", qv(out_p, 0), 8'h40);
        chk("rd_seq_pc1", qv(out_p, 1), 8'h41);
        chk("rd_seq_pc2", qv(out_p, 2), 8'h42);

        // Halt on 0xFF at pc 3, then redirect to 0x10
        fill_default();
        mem[3] = 8'hFF;
        do_reset(1'b1);
        step(10);
        chk("halt_iss_count", iss_a.size(), 4);
        chk("halt_out_count", out_p.size(), 4);
        chk("halt_out_pc",    qv(out_p, 3), 3);
        chk("halt_out_instr", qv(out_i, 3), 8'hFF);
        @(negedge clk);
        chk("halt_flag",    int'(bus.halted),  1);
        chk("halt_imem_en", int'(bus.imem_en), 0);
        step(1);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 8'h10;
        @(negedge clk);
        chk("halt_rd_en",   int'(bus.imem_en),   1);
        chk("halt_rd_addr", int'(bus.imem_addr), 8'h10);
        step(1);
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        chk("halt_cleared", int'(bus.halted), 0);
        step(4);
        chk("halt_resume_pc",    qv(out_p, 4), 8'h10);
        chk("halt_resume_instr", qv(out_i, 4), 8'h11);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
